// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst controller: FSM encoding and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

    localparam int DWIDTH_DEF  = 8;
    localparam int DEPTH_DEF   = 4;
    // Cycles ARM waits for the core to go busy before giving up and retrying.
    localparam int ARM_TIMEOUT = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_ARM     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous FIFO, DEPTH entries, extra-MSB pointers for full/empty.
// Latency: a push is visible on dout/empty the cycle after the push edge.
// Backpressure: push ignored when full unless popped in the same cycle; pop ignored when empty.
// Ports: clk/rst (async active-low), push+din, pop, dout (head), full, empty, count (occupancy).
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // On full, a same-cycle pop frees the slot being written, so both proceed.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst controller: queues host words, feeds them one at a time to spi_core, queues replies.
// Latency: ISSUE the cycle after a word is queued (core idle), reply in RX the cycle after CAPTURE.
// Backpressure: tx_ready drops when TX full; no transfer starts unless RX has room for its reply.
// Ports: host tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready; core_cs/wr/rd/din out,
//        core_dout/core_done in; busy while anything is queued or in flight.
module spi_burst_ctrl #(
    parameter int DWIDTH = spi_pkg::DWIDTH_DEF,
    parameter int DEPTH  = spi_pkg::DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              core_cs,
    output logic              core_wr,
    output logic              core_rd,
    output logic [DWIDTH-1:0] core_din,
    input  logic [DWIDTH-1:0] core_dout,
    input  logic              core_done,
    output logic              busy
);
    import spi_pkg::*;

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] CAP_LIMIT = (AW+1)'(DEPTH - 1);
    localparam logic [1:0]  ARM_LAST  = 2'(ARM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        arm_cnt;
    logic              retry;
    logic [DWIDTH-1:0] hold;

    logic [DWIDTH-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic [AW:0]       tx_count_unused;
    logic              tx_pop;
    logic              rx_push;
    logic              rx_full;
    logic              rx_empty;
    logic [AW:0]       rx_count;

    logic [DWIDTH-1:0] issue_word;
    logic              rx_room;
    logic              start_ok;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign core_rd  = 1'b0;
    assign busy     = (state != ST_IDLE) || !tx_empty || retry;

    // A retried word comes from the holding register; the TX FIFO already gave it up.
    assign issue_word = retry ? hold : tx_head;

    // In CAPTURE the current reply is being pushed this edge, so it must be counted
    // before committing the next transfer; in IDLE nothing is in flight.
    assign rx_room  = (state == ST_CAPTURE) ? (rx_count < CAP_LIMIT) : !rx_full;
    assign start_ok = (!tx_empty || retry) && core_done && rx_room;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            arm_cnt <= '0;
            retry   <= 1'b0;
            hold    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ISSUE) begin
                arm_cnt <= '0;
                hold    <= issue_word;
            end else if (state == ST_ARM) begin
                arm_cnt <= arm_cnt + 2'd1;
                if (!core_done) begin
                    retry <= 1'b0;
                end else if (arm_cnt == ARM_LAST) begin
                    retry <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        core_cs   = 1'b0;
        core_wr   = 1'b0;
        core_din  = '0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                core_cs   = 1'b1;
                core_wr   = 1'b1;
                core_din  = issue_word;
                tx_pop    = !retry;
                state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!core_done) begin
                    state_nxt = ST_WAIT;
                end else if (arm_cnt == ARM_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (core_done) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rx_push   = 1'b1;
                state_nxt = start_ok ? ST_ISSUE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    spi_sync_fifo #(.WIDTH(DWIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid && tx_ready),
        .din   (tx_data),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count_unused)
    );

    spi_sync_fifo #(.WIDTH(DWIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (core_dout),
        .pop   (rx_valid && rx_ready),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule
